parity_rr_sched: RTL and testbench

- Round-robin scheduler that shares one registered XOR-reduction (parity) tree among NREQ requesters.
- Each requester presents a WIDTH-bit operand under valid/ready.
- The block grants one requester per cycle, pipelines the operand through the shared tree, and returns the parity with a one-hot mask naming the winner.
- It sits between the request sources and the shared tree/mask fan-out, replacing the hard-wired single-operand, broadcast-result arrangement.

---
 rtl/parity_sched_pkg.sv | 37 +++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/parity_rr_sched.sv | 99 +++++++++
 tb/tb_parity_rr_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_sched_pkg.sv
// Shared types and the round-robin pick function for the parity scheduler.
// Purely combinational helpers; no state lives here.
package parity_sched_pkg;

  localparam int NREQ_DEF  = 3;
  localparam int WIDTH_DEF = 8;
  localparam int NREQ_MAX  = 8;

  typedef struct packed {
    logic       any;
    logic [2:0] idx;
  } pick_t;

  typedef struct packed {
    logic [NREQ_MAX-1:0] mask;
    logic                parity;
  } resp_t;

  // First eligible index scanning ptr, ptr+1, ... wrapping at nreq.
  function automatic pick_t rr_pick(input logic [NREQ_MAX-1:0] elig,
                                    input logic [2:0]          ptr,
                                    input int                  nreq);
    pick_t p;
    int    i;
    p = '0;
    for (int k = 0; k < NREQ_MAX; k++) begin
      i = int'(ptr) + k;
      if (i >= nreq) i = i - nreq;
      if ((k < nreq) && !p.any && elig[i[2:0]]) begin
        p.any = 1'b1;
        p.idx = i[2:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer register moves past the winner on accept.
// Grant is same-cycle; pointer freezes whenever acc_en_i is low.
module rr_arbiter
  import parity_sched_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] elig_i,
  input  logic            acc_en_i,
  output logic [NREQ-1:0] grant_o,
  output logic            any_o
);

  logic [IDXW-1:0]     rr_ptr_q, rr_ptr_d, nxt;
  logic [NREQ_MAX-1:0] elig_ext;
  logic [2:0]          ptr_ext;
  pick_t               pick;

  always_comb begin
    elig_ext             = '0;
    elig_ext[NREQ-1:0]   = elig_i;
    ptr_ext              = '0;
    ptr_ext[IDXW-1:0]    = rr_ptr_q;
    pick                 = rr_pick(elig_ext, ptr_ext, NREQ);
    grant_o              = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_o[i] = pick.any && (pick.idx == 3'(i));
    end
    any_o    = pick.any;
    nxt      = (pick.idx == 3'(NREQ-1)) ? '0 : IDXW'(pick.idx + 3'd1);
    rr_ptr_d = (pick.any && acc_en_i) ? nxt : rr_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/parity_rr_sched.sv
// Round-robin share of one registered parity tree among NREQ requesters; accept to response is 2 cycles.
// Both stages hold under resp_ready=0 and req_ready drops once S1 cannot advance.
module parity_rr_sched
  import parity_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       cfg_en,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  output logic [NREQ-1:0]       resp_mask,
  output logic                  resp_parity,
  input  logic                  resp_ready,
  output logic                  busy
);

  logic [NREQ-1:0]  elig, grant;
  logic             any_gnt, adv1, adv2, acc_en;
  logic [WIDTH-1:0] sel_data;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic [NREQ-1:0]  s1_mask_q, s1_mask_d;
  logic             s2_valid_q, s2_valid_d;
  logic             s2_parity_q, s2_parity_d;
  logic [NREQ-1:0]  s2_mask_q, s2_mask_d;

  assign elig   = req_valid & cfg_en;
  assign adv2   = ~s2_valid_q | resp_ready;
  assign adv1   = ~s1_valid_q | adv2;
  // Nothing may be accepted while reset is held, even though the grant logic is live.
  assign acc_en = adv1 & ~rst;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .elig_i   (elig),
    .acc_en_i (acc_en),
    .grant_o  (grant),
    .any_o    (any_gnt)
  );

  assign req_ready = grant & {NREQ{acc_en}};

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) sel_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_mask_d   = s1_mask_q;
    s2_valid_d  = s2_valid_q;
    s2_parity_d = s2_parity_q;
    s2_mask_d   = s2_mask_q;
    if (adv2) begin
      s2_valid_d  = s1_valid_q;
      s2_parity_d = ^s1_data_q;
      s2_mask_d   = s1_mask_q;
    end
    if (adv1) begin
      s1_valid_d = any_gnt;
      s1_data_d  = sel_data;
      s1_mask_d  = grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_mask_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_parity_q <= 1'b0;
      s2_mask_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_mask_q   <= s1_mask_d;
      s2_valid_q  <= s2_valid_d;
      s2_parity_q <= s2_parity_d;
      s2_mask_q   <= s2_mask_d;
    end
  end

  assign resp_valid  = s2_valid_q;
  assign resp_mask   = s2_mask_q;
  assign resp_parity = s2_parity_q;
  assign busy        = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_parity_rr_sched.sv
// Directed scenarios for parity_rr_sched with a queue scoreboard tracking every accept to its response.
module tb_parity_rr_sched;
  import parity_sched_pkg::*;

  localparam int NREQ  = 3;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       cfg_en = '0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  resp_valid;
  logic [NREQ-1:0]       resp_mask;
  logic                  resp_parity;
  logic                  resp_ready = 1'b0;
  logic                  busy;

  logic [WIDTH-1:0] d [NREQ];
  int    checks = 0;
  int    errors = 0;
  resp_t sb [$];

  assign req_data = {d[2], d[1], d[0]};

  always #5 clk = ~clk;

  parity_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_en      (cfg_en),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_mask   (resp_mask),
    .resp_parity (resp_parity),
    .resp_ready  (resp_ready),
    .busy        (busy)
  );

  // Scoreboard: push on every accept, pop and compare on every response handshake.
  always @(negedge clk) begin
    resp_t e;
    if (!rst) begin
      if (resp_valid && resp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got mask %b parity %b exp no response", resp_mask, resp_parity);
        end else begin
          e = sb.pop_front();
          if (resp_mask !== e.mask[NREQ-1:0] || resp_parity !== e.parity) begin
            errors++;
            $display("FAIL sb_resp got mask %b parity %b exp mask %b parity %b",
                     resp_mask, resp_parity, e.mask[NREQ-1:0], e.parity);
          end
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e         = '0;
          e.mask[i] = 1'b1;
          e.parity  = ^d[i];
          sb.push_back(e);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    req_valid = 3'b111;
    cfg_en    = 3'b111;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || resp_mask !== 3'b000 || resp_parity !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp got v%b m%b p%b exp v0 m000 p0", resp_valid, resp_mask, resp_parity);
    end
    checks++;
    if (busy !== 1'b0 || req_ready !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl got busy %b ready %b exp busy 0 ready 000", busy, req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    rst       = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [2:0] e_rdy [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    logic       e_rv  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0] e_rm  [5] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b100};
    logic       e_rp  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    d[0] = 8'h01; d[1] = 8'h03; d[2] = 8'h07;
    cfg_en = 3'b111; resp_ready = 1'b1; req_valid = 3'b111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== e_rdy[k]) begin
        errors++;
        $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, e_rdy[k]);
      end
      checks++;
      if (resp_valid !== e_rv[k] || (e_rv[k] && (resp_mask !== e_rm[k] || resp_parity !== e_rp[k]))) begin
        errors++;
        $display("FAIL rr_resp[%0d] got v%b m%b p%b exp v%b m%b p%b", k,
                 resp_valid, resp_mask, resp_parity, e_rv[k], e_rm[k], e_rp[k]);
      end
      @(posedge clk);
      #1;
    end
    req_valid = 3'b000;
    idle(3);
  endtask

  task automatic test_backpressure();
    logic [2:0] e_rdy [7] = '{3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    logic       e_rv  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] e_rm  [7] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b010, 3'b000};
    logic       e_rp  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       e_bz  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    resp_ready = 1'b0; req_valid = 3'b011;
    for (int k = 0; k < 7; k++) begin
      if (k == 4) begin
        resp_ready = 1'b1;
        req_valid  = 3'b000;
        #1;
      end
      @(negedge clk);
      checks++;
      if (req_ready !== e_rdy[k] || busy !== e_bz[k]) begin
        errors++;
        $display("FAIL bp_ctl[%0d] got ready %b busy %b exp ready %b busy %b", k,
                 req_ready, busy, e_rdy[k], e_bz[k]);
      end
      checks++;
      if (resp_valid !== e_rv[k] || (e_rv[k] && (resp_mask !== e_rm[k] || resp_parity !== e_rp[k]))) begin
        errors++;
        $display("FAIL bp_resp[%0d] got v%b m%b p%b exp v%b m%b p%b", k,
                 resp_valid, resp_mask, resp_parity, e_rv[k], e_rm[k], e_rp[k]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_fairness();
    logic [2:0] e_rdy [8] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    resp_ready = 1'b1; cfg_en = 3'b111;
    for (int k = 0; k < 8; k++) begin
      req_valid = (k < 5) ? 3'b100 : 3'b111;
      #1;
      @(negedge clk);
      checks++;
      if (req_ready !== e_rdy[k]) begin
        errors++;
        $display("FAIL fair_ready[%0d] got %b exp %b", k, req_ready, e_rdy[k]);
      end
      @(posedge clk);
      #1;
    end
    req_valid = 3'b000;
    idle(3);
  endtask

  task automatic test_cfg_mask();
    logic [2:0] e_rdy [5] = '{3'b010, 3'b100, 3'b001, 3'b100, 3'b001};
    resp_ready = 1'b1; req_valid = 3'b111;
    for (int k = 0; k < 5; k++) begin
      cfg_en = (k == 0) ? 3'b010 : 3'b101;
      #1;
      @(negedge clk);
      checks++;
      if (req_ready !== e_rdy[k]) begin
        errors++;
        $display("FAIL cfg_ready[%0d] got %b exp %b", k, req_ready, e_rdy[k]);
      end
      if (k == 2) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_mask !== 3'b010 || resp_parity !== 1'b0) begin
          errors++;
          $display("FAIL cfg_inflight got v%b m%b p%b exp v1 m010 p0", resp_valid, resp_mask, resp_parity);
        end
      end
      @(posedge clk);
      #1;
    end
    req_valid = 3'b000;
    cfg_en    = 3'b111;
    idle(3);
  endtask

  task automatic test_async_reset();
    resp_ready = 1'b0; req_valid = 3'b111; cfg_en = 3'b111;
    idle(2);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || resp_valid !== 1'b1 || req_ready !== 3'b000) begin
      errors++;
      $display("FAIL ar_full got busy %b v%b ready %b exp busy 1 v1 ready 000", busy, resp_valid, req_ready);
    end
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_mask !== 3'b000 || req_ready !== 3'b000) begin
      errors++;
      $display("FAIL ar_assert got v%b busy %b m%b ready %b exp v0 busy 0 m000 ready 000",
               resp_valid, busy, resp_mask, req_ready);
    end
    @(posedge clk);
    #1;
    rst        = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 3'b001) begin
      errors++;
      $display("FAIL ar_first_grant got %b exp 001", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    idle(3);
  endtask

  task automatic test_parity_sweep();
    logic [7:0] vals [4] = '{8'h00, 8'hFF, 8'h80, 8'hA5};
    logic       e_p  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    resp_ready = 1'b1; cfg_en = 3'b111;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        d[0]      = vals[k];
        req_valid = 3'b001;
      end else begin
        req_valid = 3'b000;
      end
      #1;
      @(negedge clk);
      checks++;
      if (req_ready !== ((k < 4) ? 3'b001 : 3'b000)) begin
        errors++;
        $display("FAIL sweep_ready[%0d] got %b", k, req_ready);
      end
      if (k >= 2) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_mask !== 3'b001 || resp_parity !== e_p[k-2]) begin
          errors++;
          $display("FAIL sweep_parity[%0d] got v%b m%b p%b exp v1 m001 p%b", k - 2,
                   resp_valid, resp_mask, resp_parity, e_p[k-2]);
        end
      end
      @(posedge clk);
      #1;
    end
    idle(2);
  endtask

  initial begin
    d[0] = '0; d[1] = '0; d[2] = '0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_fairness();
    test_cfg_mask();
    test_async_reset();
    test_parity_sweep();
    @(negedge clk);
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL final_drain got pending %0d busy %b exp pending 0 busy 0", sb.size(), busy);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
